// File: rtl/capture_dump_seq.sv
// Capture RAM dump sequencer feeding the byte-serial UART transmitter.
// Frame layout: header, N bytes from a circular buffer, XOR checksum.
module capture_dump_seq #(
  parameter int          ADDR_W = 10,
  parameter int          DEPTH  = 1024,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   byte_cnt,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              trmt,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              dump_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT,
    S_RD,
    S_DATA,
    S_CSUM,
    S_FIN,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining;
  logic [7:0]        csum;
  logic              csum_sent;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // frame bookkeeping: address, byte count, running checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      addr_q    <= '0;
      remaining <= '0;
      csum      <= '0;
      csum_sent <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        addr      <= start_addr;
        remaining <= (byte_cnt > DEPTH_N) ? DEPTH_N : byte_cnt;
        csum      <= '0;
        csum_sent <= 1'b0;
      end
      if (state == S_RD) addr_q <= addr;
      if (state == S_DATA) begin
        csum      <= csum ^ rd_data;
        addr      <= (addr == LAST) ? '0 : addr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end
      if (state == S_CSUM) csum_sent <= 1'b1;
    end
  end

  // next state and per-state strobes
  always_comb begin
    state_nx  = state;
    trmt      = 1'b0;
    tx_data   = '0;
    rd_en     = 1'b0;
    dump_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_HDR;
      end
      S_HDR: begin
        trmt     = 1'b1;
        tx_data  = HDR;
        state_nx = abort ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (abort)                  state_nx = S_DRAIN;
        else if (tx_done) begin
          if (remaining != '0)      state_nx = S_RD;
          else if (!csum_sent)      state_nx = S_CSUM;
          else                      state_nx = S_FIN;
        end
      end
      S_RD: begin
        rd_en    = 1'b1;
        state_nx = abort ? S_DRAIN : S_DATA;
      end
      S_DATA: begin
        trmt     = 1'b1;
        tx_data  = rd_data;
        state_nx = abort ? S_DRAIN : S_WAIT;
      end
      S_CSUM: begin
        trmt     = 1'b1;
        tx_data  = csum;
        state_nx = abort ? S_DRAIN : S_WAIT;
      end
      S_FIN: begin
        dump_done = 1'b1;
        state_nx  = S_IDLE;
      end
      S_DRAIN: begin
        if (tx_done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign rd_addr = (state == S_RD) ? addr : addr_q;
  assign busy    = (state != S_IDLE);

endmodule
